// File: rtl/beam_pkg.sv
// Shared definitions for the beamformer delay bank.
// Holds the default channel count, sample width, delay range and beam
// count, the helper functions that derive the delay and sum widths, and the
// packed per-channel sample vector type for the default configuration.
package beam_pkg;

   localparam int NUM_CH_DEF    = 16;
   localparam int DATA_W_DEF    = 19;
   localparam int MAX_DELAY_DEF = 63;
   localparam int NUM_BEAMS_DEF = 32;

   // Width of one delay value; the ring depth is 2**dly_w.
   function automatic int dly_w(input int max_delay);
      return $clog2(max_delay + 1);
   endfunction

   // Sum width that cannot overflow for num_ch signed data_w inputs.
   function automatic int sum_w(input int data_w, input int num_ch);
      return data_w + $clog2(num_ch);
   endfunction

   typedef logic [NUM_CH_DEF-1:0][DATA_W_DEF-1:0] pcm_vec_t;

endpackage

// File: rtl/delay_ring.sv
// One channel of the delay bank.
// A 2**DLY_W x DATA_W simple dual-port RAM written at the shared pointer and
// read (registered) at pointer minus delay. A zero delay bypasses the RAM,
// and a delay reaching past the samples written so far reads as zero.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   wr_en      new sample this cycle
//   wr_ptr     shared ring write address
//   fill       samples written before this one (saturating)
//   delay      delay to apply to this sample
//   data       input sample
//   sample     delayed sample, valid the cycle after wr_en
module delay_ring
   import beam_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DLY_W  = dly_w(MAX_DELAY_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DLY_W-1:0]  wr_ptr,
   input  logic [DLY_W:0]    fill,
   input  logic [DLY_W-1:0]  delay,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] sample
);

   localparam int DEPTH = 1 << DLY_W;

   logic [DATA_W-1:0] ram [DEPTH];
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] byp_data;
   logic [DLY_W-1:0]  act_delay;
   logic              blank;
   logic [DLY_W-1:0]  rd_addr;

   assign rd_addr = wr_ptr - delay;

   // RAM port kept free of reset so it maps onto block RAM. A zero delay
   // never reads, which also keeps read and write addresses distinct.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ram[wr_ptr] <= data;
      end
      if (wr_en && (delay != '0)) begin
         rd_data <= ram[rd_addr];
      end
   end

   // Blank starts set so nothing unwritten can leak out after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_delay <= '0;
         blank     <= 1'b1;
         byp_data  <= '0;
      end else if (wr_en) begin
         act_delay <= delay;
         blank     <= ({1'b0, delay} > fill);
         byp_data  <= data;
      end
   end

   assign sample = blank               ? '0       :
                   (act_delay == '0)   ? byp_data : rd_data;

endmodule

// File: rtl/beam_delay_array.sv
// Multi-channel steered delay bank with delay-and-sum output.
// Each channel is delayed by a whole number of samples taken from a per-beam
// steering table; the delayed channels and their signed sum come out two
// cycles after each input sample.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     one sample on all channels this cycle
//   pcm_in       channel c at [c*DATA_W +: DATA_W], signed
//   beam_sel     beam for this sample (out of range selects beam 0)
//   cfg_we       steering-table write strobe
//   cfg_beam     table row, cfg_ch table column, cfg_delay value (clamped)
//   out_valid    one-cycle pulse with pcm_out / sum_out / active_beam
module beam_delay_array
   import beam_pkg::*;
#(
   parameter  int NUM_CH    = NUM_CH_DEF,
   parameter  int DATA_W    = DATA_W_DEF,
   parameter  int MAX_DELAY = MAX_DELAY_DEF,
   parameter  int NUM_BEAMS = NUM_BEAMS_DEF,
   localparam int DLY_W     = dly_w(MAX_DELAY),
   localparam int SUM_W     = sum_w(DATA_W, NUM_CH),
   localparam int BEAM_W    = $clog2(NUM_BEAMS),
   localparam int CH_W      = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [NUM_CH*DATA_W-1:0] pcm_in,
   input  logic [BEAM_W-1:0]        beam_sel,
   input  logic                     cfg_we,
   input  logic [BEAM_W-1:0]        cfg_beam,
   input  logic [CH_W-1:0]          cfg_ch,
   input  logic [DLY_W:0]           cfg_delay,
   output logic                     out_valid,
   output logic [NUM_CH*DATA_W-1:0] pcm_out,
   output logic signed [SUM_W-1:0]  sum_out,
   output logic [BEAM_W-1:0]        active_beam
);

   localparam int               DEPTH = 1 << DLY_W;
   localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);

   logic [DLY_W-1:0]         steer [NUM_BEAMS][NUM_CH];
   logic [DLY_W-1:0]         cfg_val;
   logic                     cfg_beam_ok;
   logic                     cfg_ch_ok;
   logic [BEAM_W-1:0]        beam_eff;
   logic [DLY_W-1:0]         wr_ptr;
   logic [DLY_W:0]           fill;
   logic                     valid_pipe;
   logic [BEAM_W-1:0]        beam_pipe;
   logic [DATA_W-1:0]        smp [NUM_CH];
   logic [NUM_CH*DATA_W-1:0] pcm_next;
   logic signed [SUM_W-1:0]  sum_next;

   assign cfg_val = (cfg_delay > (DLY_W+1)'(MAX_DELAY)) ? MAX_D : cfg_delay[DLY_W-1:0];

   // Range checks collapse to constants when the index width is exactly full.
   if (NUM_BEAMS == (1 << BEAM_W)) begin : g_beam_full
      assign cfg_beam_ok = 1'b1;
      assign beam_eff    = beam_sel;
   end else begin : g_beam_part
      assign cfg_beam_ok = (cfg_beam < BEAM_W'(NUM_BEAMS));
      assign beam_eff    = (beam_sel < BEAM_W'(NUM_BEAMS)) ? beam_sel : '0;
   end

   if (NUM_CH == (1 << CH_W)) begin : g_ch_full
      assign cfg_ch_ok = 1'b1;
   end else begin : g_ch_part
      assign cfg_ch_ok = (cfg_ch < CH_W'(NUM_CH));
   end

   // Steering table: one register per entry. A write in the same cycle as a
   // read of that row is seen by the next sample, not the current one.
   genvar gi, gj;
   for (gi = 0; gi < NUM_BEAMS; gi++) begin : g_row
      for (gj = 0; gj < NUM_CH; gj++) begin : g_col
         logic [DLY_W-1:0] entry;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               entry <= '0;
            end else if (cfg_we && cfg_beam_ok && cfg_ch_ok &&
                         (cfg_beam == BEAM_W'(gi)) && (cfg_ch == CH_W'(gj))) begin
               entry <= cfg_val;
            end
         end
         assign steer[gi][gj] = entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         fill   <= '0;
      end else if (in_valid) begin
         wr_ptr <= wr_ptr + 1'b1;
         if (fill != (DLY_W+1)'(DEPTH)) begin
            fill <= fill + 1'b1;
         end
      end
   end

   // All channels latch their delay from the same row on the same edge, so a
   // beam change can never produce a mixed-beam sample.
   for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      delay_ring #(
         .DATA_W (DATA_W),
         .DLY_W  (DLY_W)
      ) u_ring (
         .clk    (clk),
         .rst    (rst),
         .wr_en  (in_valid),
         .wr_ptr (wr_ptr),
         .fill   (fill),
         .delay  (steer[beam_eff][gi]),
         .data   (pcm_in[gi*DATA_W +: DATA_W]),
         .sample (smp[gi])
      );
      assign pcm_next[gi*DATA_W +: DATA_W] = smp[gi];
   end

   always_comb begin
      sum_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum_next = sum_next + SUM_W'($signed(smp[i]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_pipe  <= 1'b0;
         beam_pipe   <= '0;
         out_valid   <= 1'b0;
         pcm_out     <= '0;
         sum_out     <= '0;
         active_beam <= '0;
      end else begin
         valid_pipe <= in_valid;
         out_valid  <= valid_pipe;
         if (in_valid) begin
            beam_pipe <= beam_eff;
         end
         if (valid_pipe) begin
            pcm_out     <= pcm_next;
            sum_out     <= sum_next;
            active_beam <= beam_pipe;
         end
      end
   end

endmodule

// File: tb/tb_beam_delay_array.sv
// Directed bench for beam_delay_array with default parameters.
// Each task drives one scenario and compares captured outputs against
// hand-derived values; a negedge monitor records every out_valid pulse.
module tb_beam_delay_array;
   import beam_pkg::*;

   localparam int NCH = 16;
   localparam int DW  = 19;
   localparam int VW  = NCH * DW;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [VW-1:0]     pcm_in;
   logic [4:0]        beam_sel;
   logic              cfg_we;
   logic [4:0]        cfg_beam;
   logic [3:0]        cfg_ch;
   logic [6:0]        cfg_delay;
   logic              out_valid;
   logic [VW-1:0]     pcm_out;
   logic signed [22:0] sum_out;
   logic [4:0]        active_beam;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [VW-1:0]      q_pcm [$];
   logic signed [22:0] q_sum [$];
   logic [4:0]         q_beam [$];
   int                 q_ocyc [$];
   int                 q_icyc [$];

   beam_delay_array dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .pcm_in      (pcm_in),
      .beam_sel    (beam_sel),
      .cfg_we      (cfg_we),
      .cfg_beam    (cfg_beam),
      .cfg_ch      (cfg_ch),
      .cfg_delay   (cfg_delay),
      .out_valid   (out_valid),
      .pcm_out     (pcm_out),
      .sum_out     (sum_out),
      .active_beam (active_beam)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid) begin
         q_pcm.push_back(pcm_out);
         q_sum.push_back(sum_out);
         q_beam.push_back(active_beam);
         q_ocyc.push_back(cyc);
      end
   end

   task automatic clear_q();
      q_pcm.delete(); q_sum.delete(); q_beam.delete();
      q_ocyc.delete(); q_icyc.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_q();
   endtask

   task automatic send(input logic [VW-1:0] v, input logic [4:0] b);
      pcm_in = v; beam_sel = b; in_valid = 1'b1;
      q_icyc.push_back(cyc);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic cfg(input int b, input int c, input int d);
      cfg_we = 1'b1; cfg_beam = 5'(b); cfg_ch = 4'(c); cfg_delay = 7'(d);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 1'b1; pcm_in = '1; beam_sel = 5'd7; cfg_we = 1'b0;
      cfg_beam = '0; cfg_ch = '0; cfg_delay = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
      checks++; if (pcm_out !== '0) begin errors++; $display("FAIL reset pcm_out got %h want 0", pcm_out); end
      checks++; if (sum_out !== '0) begin errors++; $display("FAIL reset sum_out got %0d want 0", sum_out); end
      checks++; if (active_beam !== '0) begin errors++; $display("FAIL reset active_beam got %0d want 0", active_beam); end
      in_valid = 1'b0;
      rst = 1'b0;
      $display("reset: outputs checked under reset");
   endtask

   task automatic test_impulse();
      pcm_vec_t v, ev;
      logic signed [22:0] es;
      do_reset();
      for (int c = 0; c < NCH; c++) cfg(0, c, c);
      for (int n = 0; n < 20; n++) begin
         for (int c = 0; c < NCH; c++) v[c] = (n == 0) ? 19'd1000 : 19'd0;
         send(v, 5'd0);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (q_pcm.size() != 20) begin
         errors++; $display("FAIL impulse count got %0d want 20", q_pcm.size());
      end else begin
         for (int n = 0; n < 20; n++) begin
            for (int c = 0; c < NCH; c++) ev[c] = (n == c) ? 19'd1000 : 19'd0;
            es = (n < 16) ? 23'sd1000 : 23'sd0;
            checks++; if (q_pcm[n] !== ev) begin errors++; $display("FAIL impulse pcm n=%0d got %h want %h", n, q_pcm[n], ev); end
            checks++; if (q_sum[n] !== es) begin errors++; $display("FAIL impulse sum n=%0d got %0d want %0d", n, q_sum[n], es); end
            $display("impulse: sample %0d sum %0d", n, q_sum[n]);
         end
      end
   endtask

   task automatic test_warmup();
      pcm_vec_t v, ev;
      logic signed [22:0] es;
      int x;
      do_reset();
      for (int c = 0; c < NCH; c++) cfg(0, c, 5);
      for (int k = 0; k < 12; k++) begin
         for (int c = 0; c < NCH; c++) v[c] = 19'(k + 1);
         send(v, 5'd0);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (q_pcm.size() != 12) begin
         errors++; $display("FAIL warmup count got %0d want 12", q_pcm.size());
      end else begin
         for (int k = 0; k < 12; k++) begin
            x = (k >= 5) ? k - 4 : 0;
            for (int c = 0; c < NCH; c++) ev[c] = 19'(x);
            es = 23'(16 * x);
            checks++; if (q_pcm[k] !== ev) begin errors++; $display("FAIL warmup pcm k=%0d got %h want %h", k, q_pcm[k], ev); end
            checks++; if (q_sum[k] !== es) begin errors++; $display("FAIL warmup sum k=%0d got %0d want %0d", k, q_sum[k], es); end
            checks++; if (q_ocyc[k] - q_icyc[k] != 2) begin errors++; $display("FAIL warmup latency k=%0d got %0d want 2", k, q_ocyc[k] - q_icyc[k]); end
            $display("warmup: sample %0d ch0 %0d", k, x);
         end
      end
   endtask

   task automatic test_wrap_max();
      pcm_vec_t v;
      logic [VW-1:0] g;
      logic [DW-1:0] e0;
      do_reset();
      cfg(0, 0, 100);
      for (int n = 0; n < 200; n++) begin
         for (int c = 0; c < NCH; c++) v[c] = 19'(n);
         send(v, 5'd0);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (q_pcm.size() != 200) begin
         errors++; $display("FAIL wrap count got %0d want 200", q_pcm.size());
      end else begin
         for (int n = 0; n < 200; n++) begin
            g = q_pcm[n];
            e0 = (n >= 63) ? 19'(n - 63) : 19'd0;
            checks++; if (g[DW-1:0] !== e0) begin errors++; $display("FAIL wrap ch0 n=%0d got %0d want %0d", n, g[DW-1:0], e0); end
            checks++; if (g[DW +: DW] !== 19'(n)) begin errors++; $display("FAIL wrap ch1 n=%0d got %0d want %0d", n, g[DW +: DW], n); end
         end
         $display("wrap: 200 ramp samples compared, delay 100 clamped to 63");
      end
   endtask

   task automatic test_beam_switch();
      pcm_vec_t v, ev;
      logic [4:0] eb;
      do_reset();
      for (int c = 0; c < NCH; c++) cfg(3, c, 2);
      for (int n = 0; n < 20; n++) begin
         for (int c = 0; c < NCH; c++) v[c] = 19'((n + 1) * 10);
         send(v, (n < 10) ? 5'd0 : 5'd3);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (q_pcm.size() != 20) begin
         errors++; $display("FAIL beam count got %0d want 20", q_pcm.size());
      end else begin
         for (int n = 0; n < 20; n++) begin
            for (int c = 0; c < NCH; c++) ev[c] = (n < 10) ? 19'((n + 1) * 10) : 19'((n - 1) * 10);
            eb = (n < 10) ? 5'd0 : 5'd3;
            checks++; if (q_pcm[n] !== ev) begin errors++; $display("FAIL beam pcm n=%0d got %h want %h", n, q_pcm[n], ev); end
            checks++; if (q_beam[n] !== eb) begin errors++; $display("FAIL beam active n=%0d got %0d want %0d", n, q_beam[n], eb); end
            $display("beam: sample %0d beam %0d", n, q_beam[n]);
         end
      end
   endtask

   task automatic test_write_race();
      pcm_vec_t v;
      logic [VW-1:0] g;
      logic [DW-1:0] e0;
      do_reset();
      for (int n = 0; n < 8; n++) begin
         for (int c = 0; c < NCH; c++) v[c] = 19'(n + 1);
         if (n == 4) begin
            cfg_we = 1'b1; cfg_beam = 5'd0; cfg_ch = 4'd0; cfg_delay = 7'd3;
         end
         send(v, 5'd0);
         cfg_we = 1'b0;
      end
      repeat (4) @(negedge clk);
      checks++;
      if (q_pcm.size() != 8) begin
         errors++; $display("FAIL race count got %0d want 8", q_pcm.size());
      end else begin
         for (int n = 0; n < 8; n++) begin
            g = q_pcm[n];
            e0 = (n <= 4) ? 19'(n + 1) : 19'(n - 2);
            checks++; if (g[DW-1:0] !== e0) begin errors++; $display("FAIL race ch0 n=%0d got %0d want %0d", n, g[DW-1:0], e0); end
            checks++; if (g[DW +: DW] !== 19'(n + 1)) begin errors++; $display("FAIL race ch1 n=%0d got %0d want %0d", n, g[DW +: DW], n + 1); end
            $display("race: sample %0d ch0 %0d", n, g[DW-1:0]);
         end
      end
   endtask

   task automatic test_sum_extremes();
      pcm_vec_t v;
      logic [VW-1:0] g;
      do_reset();
      for (int c = 0; c < NCH; c++) v[c] = 19'h40000;
      send(v, 5'd0);
      for (int c = 0; c < NCH; c++) v[c] = 19'h3FFFF;
      send(v, 5'd0);
      repeat (4) @(negedge clk);
      checks++;
      if (q_sum.size() != 2) begin
         errors++; $display("FAIL sumx count got %0d want 2", q_sum.size());
      end else begin
         checks++; if (q_sum[0] !== -23'sd4194304) begin errors++; $display("FAIL sumx neg got %0d want -4194304", q_sum[0]); end
         checks++; if (q_sum[1] !== 23'sd4194288) begin errors++; $display("FAIL sumx pos got %0d want 4194288", q_sum[1]); end
         $display("sumx: neg %0d pos %0d", q_sum[0], q_sum[1]);
      end
      // Mid-stream reset while an output pulse is on the port.
      for (int c = 0; c < NCH; c++) v[c] = 19'd5;
      send(v, 5'd0); send(v, 5'd0); send(v, 5'd0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst pre out_valid got %b want 1", out_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst out_valid got %b want 0", out_valid); end
      checks++; if (pcm_out !== '0) begin errors++; $display("FAIL midrst pcm_out got %h want 0", pcm_out); end
      checks++; if (sum_out !== '0) begin errors++; $display("FAIL midrst sum_out got %0d want 0", sum_out); end
      @(negedge clk);
      rst = 1'b0;
      clear_q();
      repeat (3) @(negedge clk);
      checks++; if (q_pcm.size() != 0) begin errors++; $display("FAIL midrst stale outputs got %0d want 0", q_pcm.size()); end
      $display("midrst: reset applied mid-stream");
      // Warm-up restarts: a one-sample delay sees nothing on the first sample.
      cfg(0, 0, 1);
      for (int c = 0; c < NCH; c++) v[c] = 19'd7;
      send(v, 5'd0); send(v, 5'd0);
      repeat (4) @(negedge clk);
      checks++;
      if (q_pcm.size() != 2) begin
         errors++; $display("FAIL rewarm count got %0d want 2", q_pcm.size());
      end else begin
         g = q_pcm[0];
         checks++; if (g[DW-1:0] !== 19'd0) begin errors++; $display("FAIL rewarm ch0 s0 got %0d want 0", g[DW-1:0]); end
         g = q_pcm[1];
         checks++; if (g[DW-1:0] !== 19'd7) begin errors++; $display("FAIL rewarm ch0 s1 got %0d want 7", g[DW-1:0]); end
         checks++; if (q_sum[0] !== 23'sd105) begin errors++; $display("FAIL rewarm sum s0 got %0d want 105", q_sum[0]); end
         $display("rewarm: s0 sum %0d s1 sum %0d", q_sum[0], q_sum[1]);
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_warmup();
      test_wrap_max();
      test_beam_switch();
      test_write_race();
      test_sum_extremes();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
